// File: rtl/issue_scoreboard_if.sv
// Issue/writeback/FPU handshake bundle for the DLX issue scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface issue_scoreboard_if;
  logic       iss_valid;
  logic       iss_is_fpu;
  logic       iss_we;
  logic [5:0] iss_rd;
  logic [5:0] iss_rs1;
  logic [5:0] iss_rs2;
  logic       iss_use_rs1;
  logic       iss_use_rs2;
  logic       wb_valid;
  logic [5:0] wb_rd;
  logic       iss_stall;
  logic       iss_fire;
  logic       fpu_busy;
  logic       fpu_done;
  logic [5:0] fpu_rd;

  modport master (
    output iss_valid, iss_is_fpu, iss_we, iss_rd, iss_rs1, iss_rs2,
           iss_use_rs1, iss_use_rs2, wb_valid, wb_rd,
    input  iss_stall, iss_fire, fpu_busy, fpu_done, fpu_rd
  );

  modport slave (
    input  iss_valid, iss_is_fpu, iss_we, iss_rd, iss_rs1, iss_rs2,
           iss_use_rs1, iss_use_rs2, wb_valid, wb_rd,
    output iss_stall, iss_fire, fpu_busy, fpu_done, fpu_rd
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage RAW/WAW/structural hazard scoreboard and fixed-latency FPU sequencer.
// Optional macro SB_WB_BYPASS_EN: same-cycle writeback releases dependents (write-before-read regfile).
module issue_scoreboard #(
  parameter int FPU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  issue_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] LP_LAT = CNT_W'(FPU_LAT);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [63:0]      r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_fpu_rd;
  // Remembers whether the in-flight FPU op owns a pending bit; a non-writing op must not clear one.
  logic             r_fpu_we;

  logic [63:0] w_eff;
  logic [63:0] w_set;
  logic [63:0] w_clr;
  logic        w_raw;
  logic        w_waw;
  logic        w_struct;
  logic        w_stall;
  logic        w_fire;
  logic        w_busy;
  logic        w_done;

  always_comb begin
    w_eff = r_pending;
`ifdef SB_WB_BYPASS_EN
    if (sb.wb_valid) w_eff[sb.wb_rd] = 1'b0;
`endif
  end

  assign w_busy   = (r_cnt != '0);
  assign w_done   = (r_cnt == LP_ONE);
  assign w_raw    = (sb.iss_use_rs1 & w_eff[sb.iss_rs1] & (sb.iss_rs1 != 6'd0)) |
                    (sb.iss_use_rs2 & w_eff[sb.iss_rs2] & (sb.iss_rs2 != 6'd0));
  assign w_waw    = sb.iss_we & (sb.iss_rd != 6'd0) & w_eff[sb.iss_rd];
  assign w_struct = sb.iss_is_fpu & w_busy;
  assign w_stall  = sb.iss_valid & (w_raw | w_waw | w_struct);
  assign w_fire   = sb.iss_valid & ~w_stall;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_fire && sb.iss_we && (sb.iss_rd != 6'd0)) w_set[sb.iss_rd] = 1'b1;
    if (sb.wb_valid) w_clr[sb.wb_rd] = 1'b1;
    if (w_done && r_fpu_we) w_clr[r_fpu_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_fpu_rd  <= '0;
      r_fpu_we  <= 1'b0;
    end else begin
      // Set after clear so a same-edge reissue of the writeback target stays pending.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_fire && sb.iss_is_fpu) begin
        r_cnt    <= LP_LAT;
        r_fpu_rd <= sb.iss_rd;
        r_fpu_we <= sb.iss_we & (sb.iss_rd != 6'd0);
      end else if (w_busy) begin
        r_cnt <= r_cnt - LP_ONE;
      end
    end
  end

  assign sb.iss_stall = w_stall;
  assign sb.iss_fire  = w_fire;
  assign sb.fpu_busy  = w_busy;
  assign sb.fpu_done  = w_done;
  assign sb.fpu_rd    = r_fpu_rd;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard; FPU completions are checked against a queue of expected (rd, cycle).
module tb_issue_scoreboard;

  localparam int LAT = 4;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic [5:0] q_rd[$];
  int         q_cyc[$];

  issue_scoreboard_if sb_if ();

  issue_scoreboard #(.FPU_LAT(LAT), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .sb      (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FPU completion monitor: every fpu_done must match the oldest expected entry, on time.
  always @(negedge clk) begin
    logic [5:0] exp_rd;
    int         exp_cyc;
    if (sb_if.fpu_done !== 1'b0) begin
      n_vec++;
      if (q_rd.size() == 0) begin
        n_err++;
        $display("FAIL fpu_done_unexpected: cyc=%0d fpu_done=%b fpu_rd=%0d, none expected", cyc, sb_if.fpu_done, sb_if.fpu_rd);
      end else begin
        exp_rd  = q_rd.pop_front();
        exp_cyc = q_cyc.pop_front();
        if (sb_if.fpu_rd !== exp_rd || cyc != exp_cyc) begin
          n_err++;
          $display("FAIL fpu_done: got rd=%0d cyc=%0d, expected rd=%0d cyc=%0d", sb_if.fpu_rd, cyc, exp_rd, exp_cyc);
        end
      end
    end else if (q_cyc.size() != 0 && cyc > q_cyc[0]) begin
      n_vec++;
      n_err++;
      $display("FAIL fpu_done_missing: cyc=%0d, expected rd=%0d at cyc=%0d", cyc, q_rd[0], q_cyc[0]);
      void'(q_rd.pop_front());
      void'(q_cyc.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic we, input logic [5:0] rd,
                       input logic [5:0] rs1, input logic [5:0] rs2, input logic u1, input logic u2);
    sb_if.iss_valid   = v;
    sb_if.iss_is_fpu  = f;
    sb_if.iss_we      = we;
    sb_if.iss_rd      = rd;
    sb_if.iss_rs1     = rs1;
    sb_if.iss_rs2     = rs2;
    sb_if.iss_use_rs1 = u1;
    sb_if.iss_use_rs2 = u2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    sb_if.wb_valid = 1'b0;
    sb_if.wb_rd    = 6'd0;
  endtask

  // Issue an FPU op expected to fire at the coming edge and record its completion.
  task automatic issue_fpu(input logic we, input logic [5:0] rd, input string name);
    drive(1'b1, 1'b1, we, rd, 6'd0, 6'd0, 1'b0, 1'b0);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_fire: stall/fire=%b%b, expected 01", name, sb_if.iss_stall, sb_if.iss_fire);
    end
    q_rd.push_back(rd);
    q_cyc.push_back(cyc + LAT);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 6'd5, 6'd5, 6'd40, 1'b1, 1'b1);
    #1;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire, sb_if.fpu_busy, sb_if.fpu_done} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_outputs: stall/fire/busy/done=%b%b%b%b, expected 0100",
               sb_if.iss_stall, sb_if.iss_fire, sb_if.fpu_busy, sb_if.fpu_done);
    end
    sb_if.iss_valid = 1'b0;
    #1;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_fire_follows_valid: stall/fire=%b%b, expected 00", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b0, 1'b1, 6'd5, 6'd1, 6'd2, 1'b1, 1'b1);
    #2;
    n_vec++;
    if (sb_if.iss_fire !== 1'b1) begin
      n_err++;
      $display("FAIL raw_producer_fire: fire=%b, expected 1", sb_if.iss_fire);
    end
    step();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd5, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #2;
      n_vec++;
      if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
        n_err++;
        $display("FAIL raw_stall[%0d]: stall/fire=%b%b, expected 10", i, sb_if.iss_stall, sb_if.iss_fire);
      end
      step();
    end
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd5;
    #2;
    n_vec++;
`ifdef SB_WB_BYPASS_EN
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL raw_wb_cycle: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
`else
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
      n_err++;
      $display("FAIL raw_wb_cycle: stall/fire=%b%b, expected 10", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    sb_if.wb_valid = 1'b0;
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL raw_after_wb: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
`endif
    idle();
  endtask

  task automatic test_fpu();
    issue_fpu(1'b1, 6'd34, "fpu_a");
    drive(1'b1, 1'b1, 1'b1, 6'd40, 6'd0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      #2;
      n_vec++;
      if ({sb_if.iss_stall, sb_if.fpu_busy} !== 2'b11) begin
        n_err++;
        $display("FAIL fpu_struct_stall[%0d]: stall/busy=%b%b, expected 11", i, sb_if.iss_stall, sb_if.fpu_busy);
      end
      step();
    end
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire, sb_if.fpu_busy} !== 3'b010) begin
      n_err++;
      $display("FAIL fpu_second_release: stall/fire/busy=%b%b%b, expected 010", sb_if.iss_stall, sb_if.iss_fire, sb_if.fpu_busy);
    end
    q_rd.push_back(6'd40);
    q_cyc.push_back(cyc + LAT);
    step();
    idle();
    repeat (LAT) step();
    issue_fpu(1'b1, 6'd34, "fpu_b");
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd34, 6'd40, 1'b1, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      #2;
      n_vec++;
      if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
        n_err++;
        $display("FAIL fpu_reader_stall[%0d]: stall/fire=%b%b, expected 10", i, sb_if.iss_stall, sb_if.iss_fire);
      end
      step();
    end
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL fpu_reader_release: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    idle();
  endtask

  task automatic test_r0();
    drive(1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL r0_write: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    drive(1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL r0_read: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    drive(1'b1, 1'b0, 1'b1, 6'd32, 6'd0, 6'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd3, 6'd32, 1'b1, 1'b1);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
      n_err++;
      $display("FAIL f0_is_ordinary: stall/fire=%b%b, expected 10", sb_if.iss_stall, sb_if.iss_fire);
    end
    idle();
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd32;
    step();
    idle();
  endtask

  task automatic test_waw();
    drive(1'b1, 1'b0, 1'b1, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b1, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0);
    repeat (2) begin
      #2;
      n_vec++;
      if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
        n_err++;
        $display("FAIL waw_stall: stall/fire=%b%b, expected 10", sb_if.iss_stall, sb_if.iss_fire);
      end
      step();
    end
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd7;
    #2;
    n_vec++;
`ifdef SB_WB_BYPASS_EN
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL waw_wb_cycle: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
`else
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b10) begin
      n_err++;
      $display("FAIL waw_wb_cycle: stall/fire=%b%b, expected 10", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    sb_if.wb_valid = 1'b0;
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL waw_after_wb: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
`endif
    // The reissued write to r7 is pending again; retire it.
    idle();
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd7;
    step();
    idle();
  endtask

  task automatic test_dual_clear();
    drive(1'b1, 1'b0, 1'b1, 6'd9, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    issue_fpu(1'b1, 6'd35, "dual_fpu");
    repeat (LAT - 1) step();
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd9;
    step();
    idle();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd9, 6'd35, 1'b1, 1'b1);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.iss_fire} !== 2'b01) begin
      n_err++;
      $display("FAIL dual_clear: stall/fire=%b%b, expected 01", sb_if.iss_stall, sb_if.iss_fire);
    end
    step();
    idle();
  endtask

  task automatic test_fpu_nowe();
    drive(1'b1, 1'b0, 1'b1, 6'd12, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    issue_fpu(1'b0, 6'd12, "nowe_fpu");
    repeat (LAT) step();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd12, 6'd0, 1'b1, 1'b0);
    #2;
    n_vec++;
    if ({sb_if.iss_stall, sb_if.fpu_busy} !== 2'b10) begin
      n_err++;
      $display("FAIL fpu_nowe_keeps_pending: stall/busy=%b%b, expected 10", sb_if.iss_stall, sb_if.fpu_busy);
    end
    idle();
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = 6'd12;
    step();
    idle();
  endtask

  task automatic test_reset_abort();
    issue_fpu(1'b1, 6'd38, "abort_fpu");
    step();
    step();
    reset = 1'b1;
    q_rd.delete();
    q_cyc.delete();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd38, 6'd0, 1'b1, 1'b0);
    #1;
    n_vec++;
    if ({sb_if.fpu_busy, sb_if.fpu_done, sb_if.iss_stall, sb_if.iss_fire} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_abort: busy/done/stall/fire=%b%b%b%b, expected 0001",
               sb_if.fpu_busy, sb_if.fpu_done, sb_if.iss_stall, sb_if.iss_fire);
    end
    idle();
    step();
    reset = 1'b0;
    repeat (LAT + 2) step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_raw();
    test_fpu();
    test_r0();
    test_waw();
    test_dual_clear();
    test_fpu_nowe();
    test_reset_abort();
    repeat (2) step();
    n_vec++;
    if (q_rd.size() != 0) begin
      n_err++;
      $display("FAIL fpu_queue_drained: %0d outstanding, expected 0", q_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue-stage hazard controller for the pipelined DLX core. It tracks in-flight writes to the 64-entry unified register file: r0-r31 at addresses 0-31, f0-f31 at addresses 32-63, using the same {FPSrc/FPDest, reg} 6-bit encoding as the regfile. It stalls issue on RAW and WAW hazards. It also sequences the unpipelined multi-cycle FPU, handing its result to writeback after a fixed latency.

Parameters:
FPU_LAT, 4, FPU latency in cycles from issue edge to fpu_done; legal range 1-15.
CNT_W, 4, width of the FPU countdown counter; must hold FPU_LAT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
iss_valid  in  1  decoded instruction present at issue
iss_is_fpu  in  1  instruction executes on FPU
iss_we  in  1  instruction writes a register
iss_rd  in  6  destination address
iss_rs1  in  6  source A address
iss_rs2  in  6  source B address
iss_use_rs1  in  1  rs1 is read
iss_use_rs2  in  1  rs2 is read
wb_valid  in  1  non-FPU writeback this cycle
wb_rd  in  6  non-FPU writeback address
iss_stall  out  1  hold IF/ID, inject bubble
iss_fire  out  1  instruction issues at next edge
fpu_busy  out  1  FPU occupied
fpu_done  out  1  FPU result valid for writeback
fpu_rd  out  6  FPU result destination

Behaviour:
- State: pending[63:0]; FPU countdown cnt[CNT_W-1:0]; fpu_rd register.
- Reset (async, immediate): pending=0, cnt=0, fpu_rd=0. Outputs are then fpu_busy=0, fpu_done=0, iss_stall=0 and iss_fire=iss_valid.
- Address 0 (r0) is special:
  - It never becomes pending.
  - A source of 0 never stalls.
  - A write to 0 issues without stall.
- Address 32 (f0) is an ordinary register.
- Effective pending mask: eff = pending, with bit wb_rd masked only when the bypass feature is enabled and wb_valid=1.
- Hazard terms, all combinational:
  - raw = (use_rs1 & eff[rs1] & rs1!=0) | (use_rs2 & eff[rs2] & rs2!=0).
  - waw = iss_we & rd!=0 & eff[rd].
  - struct = iss_is_fpu & fpu_busy.
- iss_stall = iss_valid & (raw | waw | struct).
- iss_fire = iss_valid & ~iss_stall.
- At an edge with iss_fire=1:
  - If iss_we and rd!=0: set pending[rd].
  - If iss_is_fpu: cnt<=FPU_LAT and fpu_rd<=iss_rd.
- FPU countdown:
  - fpu_busy = (cnt!=0).
  - cnt decrements by 1 at each edge while nonzero, unless it is reloaded at that edge.
  - fpu_done = (cnt==1) is registered-equivalent: it is high exactly one cycle, in the cycle after the (FPU_LAT-1)th edge following issue.
  - In the fpu_done cycle fpu_busy is still 1, so a new FPU op stalls.
  - At the edge that ends the fpu_done cycle:
    - pending[fpu_rd] is cleared.
    - A new FPU op may fire at the following edge.
- Non-FPU writeback: at an edge with wb_valid=1, clear pending[wb_rd].
  - wb_rd=0 or a non-pending address is a no-op.
- Simultaneous set and clear of the same bit at one edge (possible only with bypass): set wins.
- The FPU clear and wb clear may target different bits at the same edge; both take effect.
- An FPU op with iss_we=0 still occupies the FPU for FPU_LAT cycles; fpu_done pulses and no pending bit changes.
- Reset asserted mid-operation aborts the in-flight FPU op with no fpu_done pulse.

Optional Feature:
SB_WB_BYPASS_EN.
- Defined: a same-cycle wb_valid/wb_rd match masks that bit for the hazard check (regfile write-before-read), so a dependent instruction issues in the writeback cycle.
- Undefined: eff=pending; dependents stall one extra cycle until the bit clears at the writeback edge.

Test Plan:
1. Assert reset with no clock edge -> pending=0, fpu_busy=0, fpu_done=0, iss_stall=0; iss_fire follows iss_valid.
2. Issue ADD rd=5. Then hold an instruction with rs1=5. Pulse wb_valid with wb_rd=5 three cycles later -> iss_stall=1 until the wb cycle, then:
   - With SB_WB_BYPASS_EN: iss_fire=1 in the wb cycle.
   - Without it: iss_fire=1 in the cycle after.
3. FPU_LAT=4. Fire FPU op rd=34 at edge E0 -> fpu_busy=1 after E0; fpu_done=1 with fpu_rd=34 only in the cycle between E3 and E4. A second FPU op stalls until E4 and fires at edge E5. A reader of 34 is also released at E4.
4. Issue with iss_we=1, rd=0, then an instruction with rs1=0, rs2=0 -> no stall; pending stays 0.
5. WAW: rd=7 pending; issue another write to 7 with no sources -> iss_stall=1 until wb_rd=7.
6. FPU op in flight with cnt=2: assert reset asynchronously -> fpu_busy=0, pending cleared immediately; no fpu_done pulse after reset release.
